// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared constants and helpers for sync_fifo.
// DEFAULT_BW / DEFAULT_LGFLEN defaults; depth() = 1 << lgflen.
package sync_fifo_pkg;

  localparam int DEFAULT_BW     = 2;
  localparam int DEFAULT_LGFLEN = 5;

  function automatic int depth(input int lgflen);
    return 1 << lgflen;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: simple dual-port array, sync write, async read.
// Ports: clk, we/waddr/wdata write port; raddr/rdata read port.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int BW = DEFAULT_BW,
  parameter int AW = DEFAULT_LGFLEN
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [BW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [BW-1:0] rdata
);

  localparam int DEPTH = depth(AW);

  // Contents are intentionally left unreset.
  logic [BW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through tag FIFO.
// Ports: S_AXI_ACLK, S_AXI_ARESETN (async low), i_wr/i_data push,
// i_rd pop, o_data head, o_full, o_empty, o_fill occupancy,
// o_err sticky misuse flag (only with SYNC_FIFO_ERR_EN).
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int BW     = DEFAULT_BW,
  parameter int LGFLEN = DEFAULT_LGFLEN
) (
  input  logic            S_AXI_ACLK,
  input  logic            S_AXI_ARESETN,
  input  logic            i_wr,
  input  logic [BW-1:0]   i_data,
  input  logic            i_rd,
  output logic [BW-1:0]   o_data,
  output logic            o_full,
  output logic            o_empty,
  output logic [LGFLEN:0] o_fill
`ifdef SYNC_FIFO_ERR_EN
  ,
  output logic            o_err
`endif
);

  localparam logic [LGFLEN:0] ONE =
    {{LGFLEN{1'b0}}, 1'b1};

  logic [LGFLEN:0] wptr;
  logic [LGFLEN:0] rptr;
  logic [LGFLEN:0] fill;
  logic [BW-1:0]   rdata;
  logic            w;
  logic            r;

  // A push while full rides on a same-cycle pop.
  assign w = i_wr && (!o_full || i_rd);
  assign r = i_rd && !o_empty;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wptr <= '0;
      rptr <= '0;
      fill <= '0;
    end else begin
      if (w) wptr <= wptr + ONE;
      if (r) rptr <= rptr + ONE;
      if (w && !r)      fill <= fill + ONE;
      else if (r && !w) fill <= fill - ONE;
    end
  end

  sync_fifo_mem #(
    .BW (BW),
    .AW (LGFLEN)
  ) u_mem (
    .clk   (S_AXI_ACLK),
    .we    (w),
    .waddr (wptr[LGFLEN-1:0]),
    .wdata (i_data),
    .raddr (rptr[LGFLEN-1:0]),
    .rdata (rdata)
  );

  // Pointer MSBs only disambiguate wrap; the array needs the low bits.
  logic unused_ptr_msb;
  assign unused_ptr_msb = ^{wptr[LGFLEN], rptr[LGFLEN]};

  // Full means fill == 2^LGFLEN, i.e. only the MSB set.
  assign o_full  = fill[LGFLEN];
  assign o_empty = (fill == '0);
  assign o_fill  = fill;
  assign o_data  = o_empty ? '0 : rdata;

`ifdef SYNC_FIFO_ERR_EN
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      o_err <= 1'b0;
    end else if ((i_wr && o_full && !i_rd) ||
                 (i_rd && o_empty)) begin
      o_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed self-checking bench for sync_fifo.
// BW=2, LGFLEN=5; immediate assertions at each check point.
module tb_sync_fifo;

  logic       clk;
  logic       rst_n;
  logic       i_wr;
  logic [1:0] i_data;
  logic       i_rd;
  logic [1:0] o_data;
  logic       o_full;
  logic       o_empty;
  logic [5:0] o_fill;
`ifdef SYNC_FIFO_ERR_EN
  logic       o_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  sync_fifo #(
    .BW     (2),
    .LGFLEN (5)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .i_wr          (i_wr),
    .i_data        (i_data),
    .i_rd          (i_rd),
    .o_data        (o_data),
    .o_full        (o_full),
    .o_empty       (o_empty),
    .o_fill        (o_fill)
`ifdef SYNC_FIFO_ERR_EN
    ,
    .o_err         (o_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic wr,
                     input logic rd,
                     input logic [1:0] d);
    i_wr   = wr;
    i_rd   = rd;
    i_data = d;
    @(posedge clk);
    #1;
    i_wr   = 1'b0;
    i_rd   = 1'b0;
    i_data = 2'd0;
  endtask

  task automatic pop_chk(input string tag,
                         input logic [1:0] exp);
    i_rd = 1'b1;
    #1;
    chk(tag, 32'(o_data), 32'(exp));
    @(posedge clk);
    #1;
    i_rd = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    i_wr   = 1'b0;
    i_rd   = 1'b0;
    i_data = 2'd0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_empty", 32'(o_empty), 32'd1);
    chk("rst_full",  32'(o_full),  32'd0);
    chk("rst_fill",  32'(o_fill),  32'd0);
    chk("rst_data",  32'(o_data),  32'd0);
`ifdef SYNC_FIFO_ERR_EN
    chk("rst_err",   32'(o_err),   32'd0);
`endif
    rst_n = 1'b1;

    // Ordered pass
    cyc(1'b1, 1'b0, 2'd1);
    chk("ord_fill1", 32'(o_fill), 32'd1);
    chk("ord_head1", 32'(o_data), 32'd1);
    cyc(1'b1, 1'b0, 2'd2);
    chk("ord_fill2", 32'(o_fill), 32'd2);
    cyc(1'b1, 1'b0, 2'd3);
    chk("ord_fill3", 32'(o_fill), 32'd3);
    cyc(1'b1, 1'b0, 2'd0);
    chk("ord_fill4", 32'(o_fill), 32'd4);
    chk("ord_head4", 32'(o_data), 32'd1);
    pop_chk("ord_pop1", 2'd1);
    chk("ord_fill_p1", 32'(o_fill), 32'd3);
    pop_chk("ord_pop2", 2'd2);
    chk("ord_fill_p2", 32'(o_fill), 32'd2);
    pop_chk("ord_pop3", 2'd3);
    chk("ord_fill_p3", 32'(o_fill), 32'd1);
    pop_chk("ord_pop4", 2'd0);
    chk("ord_fill_p4", 32'(o_fill), 32'd0);
    chk("ord_empty",   32'(o_empty), 32'd1);
    chk("ord_data0",   32'(o_data),  32'd0);

    // Fill to full
    for (int i = 0; i < 32; i++) begin
      cyc(1'b1, 1'b0, 2'(i % 4));
      chk("full_cnt", 32'(o_fill), 32'(i + 1));
    end
    chk("full_flag",  32'(o_full),  32'd1);
    chk("full_nempt", 32'(o_empty), 32'd0);
    cyc(1'b1, 1'b0, 2'd1);
    chk("drop_fill", 32'(o_fill), 32'd32);
    chk("drop_head", 32'(o_data), 32'd0);
`ifdef SYNC_FIFO_ERR_EN
    chk("drop_err",  32'(o_err),  32'd1);
`endif

    // Full with simultaneous push+pop
    i_wr   = 1'b1;
    i_data = 2'd3;
    pop_chk("fpp_head", 2'd0);
    i_wr   = 1'b0;
    i_data = 2'd0;
    chk("fpp_fill", 32'(o_fill), 32'd32);
    chk("fpp_full", 32'(o_full), 32'd1);
    for (int i = 1; i < 32; i++) begin
      pop_chk("drain", 2'(i % 4));
    end
    pop_chk("drain_last", 2'd3);
    chk("drain_fill",  32'(o_fill),  32'd0);
    chk("drain_empty", 32'(o_empty), 32'd1);
    chk("drain_nfull", 32'(o_full),  32'd0);

    // Empty edge cases
    cyc(1'b0, 1'b1, 2'd0);
    chk("epop_fill",  32'(o_fill),  32'd0);
    chk("epop_empty", 32'(o_empty), 32'd1);
`ifdef SYNC_FIFO_ERR_EN
    chk("epop_err",   32'(o_err),   32'd1);
`endif
    cyc(1'b1, 1'b1, 2'd2);
    chk("epp_fill", 32'(o_fill), 32'd1);
    chk("epp_data", 32'(o_data), 32'd2);
    pop_chk("epp_pop", 2'd2);
    chk("epp_fill0", 32'(o_fill), 32'd0);

    // Async reset mid-operation
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0, 2'(i % 4));
    end
    chk("ar_fill10", 32'(o_fill), 32'd10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_fill",  32'(o_fill),  32'd0);
    chk("ar_empty", 32'(o_empty), 32'd1);
    chk("ar_full",  32'(o_full),  32'd0);
    chk("ar_data",  32'(o_data),  32'd0);
`ifdef SYNC_FIFO_ERR_EN
    chk("ar_err",   32'(o_err),   32'd0);
`endif
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(1'b1, 1'b0, 2'd2);
    chk("ar_push_data", 32'(o_data), 32'd2);
    chk("ar_push_fill", 32'(o_fill), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
